// File: rtl/prng_pkg.sv
// Shared constants and types for the LFSR pseudo-random generator.
package prng_pkg;

  // Maximal-length Fibonacci tap masks (bit i set => state[i] feeds the XOR)
  localparam logic [3:0]  TAPS_W4  = 4'b1100;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [30:0] TAPS_W31 = 31'h4800_0000;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } out_state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with runtime seed load and all-zero recovery.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH        = 31,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W31,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(25)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ResetState = (SEED_DEFAULT == '0) ? WIDTH'(1) : SEED_DEFAULT;

  logic [WIDTH-1:0] state_q, state_d;
  logic             lockup_q, lockup_d;

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = seed;
    end else if (en) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
    // A zero state would stick forever; replace it and flag the event.
    lockup_d = (state_d == '0);
    if (lockup_d) begin
      state_d = WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ResetState;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  assign state  = state_q;
  assign lockup = lockup_q;

endmodule

// File: rtl/prng_lfsr_gen.sv
// LFSR random source delivering one sample every 2^INTERVAL_LOG2 enabled cycles
// over a valid/ready port, with overrun reporting and a free-running random bit.
module prng_lfsr_gen
  import prng_pkg::*;
#(
  parameter int unsigned      WIDTH         = 31,
  parameter logic [WIDTH-1:0] TAPS          = TAPS_W31,
  parameter logic [WIDTH-1:0] SEED_DEFAULT  = WIDTH'(25),
  parameter int unsigned      OUT_WIDTH     = 8,
  parameter int unsigned      INTERVAL_LOG2 = 25
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed,
  output logic                 rnd_bit,
  output logic [OUT_WIDTH-1:0] rnd_data,
  output logic                 rnd_valid,
  input  logic                 rnd_ready,
  output logic                 overrun,
  output logic                 lockup
);

  localparam logic [INTERVAL_LOG2-1:0] CntLast = '1;

  logic [WIDTH-1:0] lfsr_state;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_core (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (lfsr_state),
    .lockup    (lockup)
  );

  logic [INTERVAL_LOG2-1:0] cnt_q, cnt_d;
  out_state_e               ostate_q, ostate_d;
  logic [OUT_WIDTH-1:0]     data_q, data_d;
  logic                     overrun_q, overrun_d;
  logic                     sample_evt;
  logic [OUT_WIDTH-1:0]     sample;
  logic                     unused_state;

  assign sample       = lfsr_state[OUT_WIDTH-1:0];
  assign unused_state = ^lfsr_state;
  // Sample is the pre-step state of the last cycle in the interval.
  assign sample_evt   = en && !seed_load && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (seed_load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    ostate_d  = ostate_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (seed_load) begin
      ostate_d  = S_EMPTY;
      overrun_d = 1'b0;
    end else begin
      unique case (ostate_q)
        S_EMPTY: begin
          if (sample_evt) begin
            data_d   = sample;
            ostate_d = S_FULL;
          end
        end
        S_FULL: begin
          if (sample_evt) begin
            if (rnd_ready) begin
              data_d = sample;
            end else begin
              overrun_d = 1'b1;
            end
          end else if (rnd_ready) begin
            ostate_d = S_EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      ostate_q  <= S_EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ostate_q  <= ostate_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign rnd_bit   = lfsr_state[WIDTH-1];
  assign rnd_data  = data_q;
  assign rnd_valid = (ostate_q == S_FULL);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Scoreboard bench for prng_lfsr_gen: a 31-bit instance for handshake/seed/reset
// behaviour and a 4-bit instance for full-period coverage.
module tb_prng_lfsr_gen;

  logic        CLK;
  logic        RST_N;
  logic        en;
  logic        seed_load;
  logic [30:0] seed;
  logic        rnd_bit;
  logic [7:0]  rnd_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        overrun;
  logic        lockup;

  logic        rst4_n;
  logic        en4;
  logic        seed_load4;
  logic [3:0]  seed4;
  logic        rnd_bit4;
  logic [3:0]  rnd_data4;
  logic        rnd_valid4;
  logic        rnd_ready4;
  logic        overrun4;
  logic        lockup4;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q8[$];
  logic [3:0]  q4[$];
  logic [15:0] mask4 = '0;
  logic        done4 = 1'b0;

  prng_lfsr_gen #(
    .INTERVAL_LOG2 (2)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .rnd_bit   (rnd_bit),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .overrun   (overrun),
    .lockup    (lockup)
  );

  prng_lfsr_gen #(
    .WIDTH         (4),
    .TAPS          (4'b1100),
    .SEED_DEFAULT  (4'd1),
    .OUT_WIDTH     (4),
    .INTERVAL_LOG2 (1)
  ) dut4 (
    .CLK       (CLK),
    .RST_N     (rst4_n),
    .en        (en4),
    .seed_load (seed_load4),
    .seed      (seed4),
    .rnd_bit   (rnd_bit4),
    .rnd_data  (rnd_data4),
    .rnd_valid (rnd_valid4),
    .rnd_ready (rnd_ready4),
    .overrun   (overrun4),
    .lockup    (lockup4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [30:0] step31(input logic [30:0] s);
    return {s[29:0], s[30] ^ s[27]};
  endfunction

  // Scoreboard monitors: compare on every accepted handshake.
  always @(negedge CLK) begin
    if (RST_N && rnd_valid && rnd_ready && !seed_load) begin
      if (q8.size() == 0) begin
        chkn("w31 unexpected sample", int'(rnd_data), -1);
      end else begin
        chk8("w31 sample", rnd_data, q8.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (rst4_n && rnd_valid4 && rnd_ready4) begin
      if (q4.size() == 0) begin
        chkn("w4 unexpected sample", int'(rnd_data4), -1);
      end else begin
        chk8("w4 sample", {4'h0, rnd_data4}, {4'h0, q4.pop_front()});
        chk1("w4 sample nonzero", rnd_data4 != 4'h0, 1'b1);
        mask4[rnd_data4] = 1'b1;
      end
    end
  end

  // 4-bit instance: x^4+x^3+1 from state 1, sampled on every second step.
  initial begin
    logic [3:0] seq4 [15];
    seq4 = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
             4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
    rst4_n     = 1'b0;
    en4        = 1'b0;
    seed_load4 = 1'b0;
    seed4      = 4'h0;
    rnd_ready4 = 1'b1;
    for (int k = 0; k < 30; k++) q4.push_back(seq4[(2 * k + 1) % 15]);
    @(posedge RST_N);
    rst4_n = 1'b1;
    en4    = 1'b1;
    repeat (60) @(posedge CLK);
    #1;
    en4 = 1'b0;
    tick(2);
    done4 = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [30:0] m;
    int          mcnt;
    logic        evt;

    RST_N     = 1'b0;
    en        = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    rnd_ready = 1'b0;
    tick(2);
    chk1("reset rnd_valid", rnd_valid, 1'b0);
    chk8("reset rnd_data", rnd_data, 8'h00);
    chk1("reset overrun", overrun, 1'b0);
    chk1("reset lockup", lockup, 1'b0);
    chk1("reset rnd_bit", rnd_bit, 1'b0);
    chk1("reset w4 rnd_bit", rnd_bit4, 1'b0);

    // Free-running capture with no consumer: 25,50,100,200 then overrun.
    RST_N = 1'b1;
    en    = 1'b1;
    tick(3);
    chk1("t1 valid before sample", rnd_valid, 1'b0);
    q8.push_back(8'hC8);
    tick(1);
    chk1("t1 valid after sample", rnd_valid, 1'b1);
    chk8("t1 first sample", rnd_data, 8'hC8);
    tick(3);
    chk1("t1 no overrun yet", overrun, 1'b0);
    tick(1);
    chk1("t1 overrun set", overrun, 1'b1);
    chk8("t1 data held on overrun", rnd_data, 8'hC8);
    chk1("t1 valid held", rnd_valid, 1'b1);

    // Zero seed with a pending sample and overrun; the handshake is discarded.
    seed_load = 1'b1;
    seed      = '0;
    rnd_ready = 1'b1;
    q8.delete();
    tick(1);
    chk1("t4 lockup pulse", lockup, 1'b1);
    chk1("t4 valid cleared", rnd_valid, 1'b0);
    chk1("t4 overrun cleared", overrun, 1'b0);
    chk1("t4 rnd_bit", rnd_bit, 1'b0);

    // en pattern 1,0,0,1,1,1 from state 1: sample is 1<<3 on the 4th enabled edge.
    seed_load = 1'b0;
    rnd_ready = 1'b0;
    tick(1);
    chk1("t4 lockup one cycle", lockup, 1'b0);
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(2);
    chk1("t5 counter frozen", rnd_valid, 1'b0);
    q8.push_back(8'h08);
    tick(1);
    chk1("t5 valid after 4 enabled", rnd_valid, 1'b1);
    chk8("t5 state frozen sample", rnd_data, 8'h08);
    en        = 1'b0;
    rnd_ready = 1'b1;
    tick(1);
    chk1("t5 consumed while en=0", rnd_valid, 1'b0);

    // Continuous consumer from a seed that engages the feedback taps.
    seed_load = 1'b1;
    seed      = 31'h4000_0003;
    en        = 1'b1;
    tick(1);
    chk1("t2 rnd_bit after seed", rnd_bit, 1'b1);
    seed_load = 1'b0;
    m         = 31'h4000_0003;
    mcnt      = 0;
    for (int i = 0; i < 12; i++) begin
      evt = (mcnt == 3);
      if (evt) q8.push_back(m[7:0]);
      m    = step31(m);
      mcnt = (mcnt + 1) % 4;
      tick(1);
      chk1("t2 valid pulse", rnd_valid, evt);
    end
    en = 1'b0;
    tick(1);
    chk1("t2 overrun stays 0", overrun, 1'b0);

    // Asynchronous reset mid-interval while a sample is pending.
    seed_load = 1'b1;
    seed      = 31'd21;
    en        = 1'b1;
    rnd_ready = 1'b0;
    tick(1);
    seed_load = 1'b0;
    tick(4);
    chk8("t6 pending sample", rnd_data, 8'hA8);
    tick(1);
    #2;
    RST_N = 1'b0;
    #1;
    chk1("t6 async valid", rnd_valid, 1'b0);
    chk8("t6 async data", rnd_data, 8'h00);
    chk1("t6 async overrun", overrun, 1'b0);
    chk1("t6 async lockup", lockup, 1'b0);
    chk1("t6 async rnd_bit", rnd_bit, 1'b0);
    tick(1);
    RST_N     = 1'b1;
    rnd_ready = 1'b1;
    tick(3);
    chk1("t6 valid before sample", rnd_valid, 1'b0);
    q8.push_back(8'hC8);
    tick(1);
    chk8("t6 seed default restored", rnd_data, 8'hC8);
    en = 1'b0;
    tick(1);
    chk1("t6 consumed", rnd_valid, 1'b0);

    for (int i = 0; i < 200 && !done4; i++) tick(1);
    chk1("w4 run completed", done4, 1'b1);
    chkn("w4 all nonzero states visited", int'(mask4), 32'hFFFE);
    chkn("w4 queue drained", q4.size(), 0);
    chk1("w4 overrun", overrun4, 1'b0);
    chk1("w4 lockup", lockup4, 1'b0);
    chkn("w31 queue drained", q8.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
